// File: rtl/inst_fetch_ctrl_if.sv
// Programming stream, inst_memory bus and decode-side fetch signals for inst_fetch_ctrl.
// The master modport is the fetch controller. The slave modport is its environment.
interface inst_fetch_ctrl_if #(
    parameter int unsigned PC_BITS   = 8,
    parameter int unsigned INST_WORD = 32,
    parameter int unsigned BYTE_SIZE = 8
);
    logic                 i_prog_mode;
    logic                 i_prog_valid;
    logic [BYTE_SIZE-1:0] i_prog_byte;
    logic                 o_prog_ready;
    logic                 o_prog_overflow;
    logic                 i_stall;
    logic                 i_branch_taken;
    logic [PC_BITS-1:0]   i_branch_target;
    logic [PC_BITS-1:0]   o_mem_address;
    logic [BYTE_SIZE-1:0] o_mem_data;
    logic                 o_mem_cs;
    logic [INST_WORD-1:0] i_mem_data;
    logic [INST_WORD-1:0] o_inst;
    logic [PC_BITS-1:0]   o_inst_pc;
    logic                 o_inst_valid;

    modport master (
        input  i_prog_mode, i_prog_valid, i_prog_byte, i_stall, i_branch_taken,
               i_branch_target, i_mem_data,
        output o_prog_ready, o_prog_overflow, o_mem_address, o_mem_data, o_mem_cs,
               o_inst, o_inst_pc, o_inst_valid
    );

    modport slave (
        output i_prog_mode, i_prog_valid, i_prog_byte, i_stall, i_branch_taken,
               i_branch_target, i_mem_data,
        input  o_prog_ready, o_prog_overflow, o_mem_address, o_mem_data, o_mem_cs,
               o_inst, o_inst_pc, o_inst_valid
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Sole driver of inst_memory. It loads the program byte by byte from the programming
// stream, then fetches 32-bit words with stall and branch redirect.
module inst_fetch_ctrl #(
    parameter int unsigned        PC_BITS   = 8,
    parameter int unsigned        INST_WORD = 32,
    parameter int unsigned        BYTE_SIZE = 8,
    parameter logic [PC_BITS-1:0] RESET_PC  = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    inst_fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, RUN} state_t;

    state_t               state;
    logic [PC_BITS-1:0]   wr_ptr;
    logic [PC_BITS-1:0]   wr_addr;
    logic [PC_BITS-1:0]   pc;
    logic [BYTE_SIZE-1:0] wr_data;
    logic                 ready_q;
    logic                 cs_q;
    logic                 overflow_q;
    logic [INST_WORD-1:0] inst_q;
    logic [PC_BITS-1:0]   inst_pc_q;
    logic                 valid_q;

    localparam logic [PC_BITS-1:0] PC_START = {RESET_PC[PC_BITS-1:2], 2'b00};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            wr_addr    <= '0;
            pc         <= PC_START;
            wr_data    <= '0;
            ready_q    <= 1'b0;
            cs_q       <= 1'b0;
            overflow_q <= 1'b0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cs_q    <= 1'b0;
                    valid_q <= 1'b0;
                    if (bus.i_prog_mode) begin
                        state      <= LOAD;
                        ready_q    <= 1'b1;
                        wr_ptr     <= '0;
                        overflow_q <= 1'b0;
                    end else begin
                        state   <= RUN;
                        ready_q <= 1'b0;
                        pc      <= PC_START;
                    end
                end
                LOAD: begin
                    // An offered byte is taken before a mode drop is honoured
                    if (bus.i_prog_valid && ready_q) begin
                        wr_data <= bus.i_prog_byte;
                        wr_addr <= wr_ptr;
                        cs_q    <= 1'b1;
                        ready_q <= 1'b0;
                        state   <= WRITE;
                    end else if (!bus.i_prog_mode) begin
                        ready_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                WRITE: begin
                    cs_q    <= 1'b0;
                    ready_q <= 1'b1;
                    wr_ptr  <= wr_ptr + PC_BITS'(1);
                    if (&wr_ptr)
                        overflow_q <= 1'b1;
                    state <= LOAD;
                end
                RUN: begin
                    if (bus.i_prog_mode) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end else if (bus.i_branch_taken) begin
                        pc      <= {bus.i_branch_target[PC_BITS-1:2], 2'b00};
                        valid_q <= 1'b0;
                    end else if (!bus.i_stall) begin
                        inst_q    <= bus.i_mem_data;
                        inst_pc_q <= pc;
                        valid_q   <= 1'b1;
                        pc        <= pc + PC_BITS'(4);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The PC owns the memory address only in RUN, so a reset or load shows the write address
    assign bus.o_mem_address   = (state == RUN) ? pc : wr_addr;
    assign bus.o_mem_data      = wr_data;
    assign bus.o_mem_cs        = cs_q;
    assign bus.o_prog_ready    = ready_q;
    assign bus.o_prog_overflow = overflow_q;
    assign bus.o_inst          = inst_q;
    assign bus.o_inst_pc       = inst_pc_q;
    assign bus.o_inst_valid    = valid_q;
endmodule
